// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO MMIO block: register offsets and the
// active-low seven-segment glyph table ({dp,g,f,e,d,c,b,a}).
package gpio_pkg;

  localparam logic [7:0] SW_VAL_OFF  = 8'h00;
  localparam logic [7:0] SW_EDGE_OFF = 8'h08;
  localparam logic [7:0] LED_OFF     = 8'h10;
  localparam logic [7:0] HEX_OFF     = 8'h18;

  localparam logic [7:0] SEG_TABLE [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/sevenseg_scan.sv
// Time-multiplexed scan of two 4-digit banks. Anodes and segments are both
// registered from the same next-digit value so they switch on the same edge.
module sevenseg_scan
  import gpio_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        i_mclk,
  input  logic        i_reset,
  input  logic [31:0] hex_next,
  output logic [3:0]  d0_a,
  output logic [3:0]  d1_a,
  output logic [7:0]  d0_seg,
  output logic [7:0]  d1_seg
);

  localparam int CW = $clog2(REFRESH_DIV + 1);

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_idx;
  logic [1:0]    digit_next;
  logic          wrap;
  logic [3:0]    d0_nib;
  logic [3:0]    d1_nib;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    wrap       = (refresh_cnt == CW'(REFRESH_DIV - 1));
    digit_next = digit_idx;
    if (wrap) digit_next = digit_idx + 2'd1;
    d0_nib = hex_next[3:0];
    d1_nib = hex_next[19:16];
    unique case (digit_next)
      2'd0: begin d0_nib = hex_next[3:0];   d1_nib = hex_next[19:16]; end
      2'd1: begin d0_nib = hex_next[7:4];   d1_nib = hex_next[23:20]; end
      2'd2: begin d0_nib = hex_next[11:8];  d1_nib = hex_next[27:24]; end
      2'd3: begin d0_nib = hex_next[15:12]; d1_nib = hex_next[31:28]; end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      d0_a        <= 4'b1110;
      d1_a        <= 4'b1110;
      d0_seg      <= SEG_TABLE[0];
      d1_seg      <= SEG_TABLE[0];
    end else begin
      refresh_cnt <= wrap ? '0 : refresh_cnt + 1'b1;
      digit_idx   <= digit_next;
      d0_a        <= ~(4'b0001 << digit_next);
      d1_a        <= ~(4'b0001 << digit_next);
      d0_seg      <= SEG_TABLE[d0_nib];
      d1_seg      <= SEG_TABLE[d1_nib];
    end
  end

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: debounced switches with sticky rising-edge flags,
// an LED register and a 32-bit hex register shown on two 4-digit displays.
module gpio_mmio
  import gpio_pkg::*;
#(
  parameter int          N               = 64,
  parameter logic [63:0] BASE            = 64'h0000_0000_0000_0800,
  parameter int          DEBOUNCE_CYCLES = 100000,
  parameter int          REFRESH_DIV     = 50000
) (
  input  logic         i_mclk,
  input  logic         i_reset,
  input  logic [15:0]  i_sw,
  input  logic [N-1:0] i_addr,
  input  logic         i_memread,
  input  logic         i_memwrite,
  input  logic [N-1:0] i_wdata,
  output logic [N-1:0] o_rdata,
  output logic         o_hit,
  output logic [15:0]  o_led,
  output logic [7:0]   D0_seg,
  output logic [7:0]   D1_seg,
  output logic [3:0]   D0_a,
  output logic [3:0]   D1_a
);

  localparam logic [N-1:0] ADDR_SW_VAL  = N'(BASE + 64'(SW_VAL_OFF));
  localparam logic [N-1:0] ADDR_SW_EDGE = N'(BASE + 64'(SW_EDGE_OFF));
  localparam logic [N-1:0] ADDR_LED     = N'(BASE + 64'(LED_OFF));
  localparam logic [N-1:0] ADDR_HEX     = N'(BASE + 64'(HEX_OFF));
  localparam int           DW           = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sel_sw_val, sel_sw_edge, sel_led, sel_hex;
  logic [15:0]   sw_meta, sw_sync, sw_samp;
  logic [15:0]   sw_val, sw_val_next, sw_edge, sw_edge_next, rise, agree;
  logic [15:0]   led;
  logic [31:0]   hex, hex_next;
  logic [DW-1:0] tick_cnt;
  logic          tick;

  always_comb begin
    sel_sw_val  = (i_addr == ADDR_SW_VAL);
    sel_sw_edge = (i_addr == ADDR_SW_EDGE);
    sel_led     = (i_addr == ADDR_LED);
    sel_hex     = (i_addr == ADDR_HEX);
    o_hit       = sel_sw_val | sel_sw_edge | sel_led | sel_hex;
    o_rdata     = '0;
    if (sel_sw_val)  o_rdata = N'(sw_val);
    if (sel_sw_edge) o_rdata = N'(sw_edge);
    if (sel_led)     o_rdata = N'(led);
    if (sel_hex)     o_rdata = N'(hex);
  end

  // A bit follows the samples only when the last two ticks saw the same level.
  always_comb begin
    tick        = (tick_cnt == DW'(DEBOUNCE_CYCLES - 1));
    agree       = ~(sw_sync ^ sw_samp);
    sw_val_next = sw_val;
    if (tick) sw_val_next = (agree & sw_sync) | (~agree & sw_val);
    rise         = sw_val_next & ~sw_val;
    sw_edge_next = ((i_memread && sel_sw_edge) ? 16'h0000 : sw_edge) | rise;
    hex_next     = (i_memwrite && sel_hex) ? i_wdata[31:0] : hex;
  end

  always_ff @(posedge i_mclk) begin
    if (i_reset) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      sw_samp  <= '0;
      sw_val   <= '0;
      sw_edge  <= '0;
      tick_cnt <= '0;
      led      <= '0;
      hex      <= '0;
    end else begin
      sw_meta  <= i_sw;
      sw_sync  <= sw_meta;
      if (tick) sw_samp <= sw_sync;
      sw_val   <= sw_val_next;
      sw_edge  <= sw_edge_next;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      if (i_memwrite && sel_led) led <= i_wdata[15:0];
      hex      <= hex_next;
    end
  end

  assign o_led = led;

  // The scanner registers from hex_next so a write shows on the very next cycle.
  sevenseg_scan #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_scan (
    .i_mclk   (i_mclk),
    .i_reset  (i_reset),
    .hex_next (hex_next),
    .d0_a     (D0_a),
    .d1_a     (D1_a),
    .d0_seg   (D0_seg),
    .d1_seg   (D1_seg)
  );

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed bench for gpio_mmio with short debounce and refresh periods.
module tb_gpio_mmio;

  localparam logic [63:0] BASE     = 64'h0000_0000_0000_0800;
  localparam logic [63:0] A_SWV    = BASE + 64'h00;
  localparam logic [63:0] A_SWE    = BASE + 64'h08;
  localparam logic [63:0] A_LED    = BASE + 64'h10;
  localparam logic [63:0] A_HEX    = BASE + 64'h18;
  localparam logic [7:0]  GLYPH [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [15:0] i_sw = '0;
  logic [63:0] i_addr = '0;
  logic        i_memread = 1'b0;
  logic        i_memwrite = 1'b0;
  logic [63:0] i_wdata = '0;
  logic [63:0] o_rdata;
  logic        o_hit;
  logic [15:0] o_led;
  logic [7:0]  D0_seg, D1_seg;
  logic [3:0]  D0_a, D1_a;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_mmio #(
    .N               (64),
    .BASE            (BASE),
    .DEBOUNCE_CYCLES (4),
    .REFRESH_DIV     (8)
  ) dut (
    .i_mclk     (clk),
    .i_reset    (i_reset),
    .i_sw       (i_sw),
    .i_addr     (i_addr),
    .i_memread  (i_memread),
    .i_memwrite (i_memwrite),
    .i_wdata    (i_wdata),
    .o_rdata    (o_rdata),
    .o_hit      (o_hit),
    .o_led      (o_led),
    .D0_seg     (D0_seg),
    .D1_seg     (D1_seg),
    .D0_a       (D0_a),
    .D1_a       (D1_a)
  );

  always #5 clk = ~clk;

  // Bus tasks start and end at 1 time unit after a rising edge.
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic store(input logic [63:0] addr, input logic [63:0] data);
    i_addr     = addr;
    i_wdata    = data;
    i_memwrite = 1'b1;
    @(posedge clk);
    #1;
    i_memwrite = 1'b0;
    i_addr     = '0;
    i_wdata    = '0;
  endtask

  task automatic load(input logic [63:0] addr, output logic [63:0] data,
                      output logic hit);
    i_addr    = addr;
    i_memread = 1'b1;
    @(negedge clk);
    data = o_rdata;
    hit  = o_hit;
    @(posedge clk);
    #1;
    i_memread = 1'b0;
    i_addr    = '0;
  endtask

  task automatic test_reset;
    logic [63:0] d;
    logic        h;
    logic [63:0] addrs [4];
    addrs = '{A_SWV, A_SWE, A_LED, A_HEX};
    i_reset = 1'b1;
    i_addr = A_LED; i_wdata = 64'hFFFF; i_memwrite = 1'b1;
    cycles(2);
    @(negedge clk);
    n_checks++; if (o_led !== 16'h0000) begin n_fail++; $display("FAIL reset_led: got %h want 0000", o_led); end
    n_checks++; if (D0_a !== 4'b1110) begin n_fail++; $display("FAIL reset_d0_a: got %b want 1110", D0_a); end
    n_checks++; if (D1_a !== 4'b1110) begin n_fail++; $display("FAIL reset_d1_a: got %b want 1110", D1_a); end
    n_checks++; if (D0_seg !== 8'hC0) begin n_fail++; $display("FAIL reset_d0_seg: got %h want C0", D0_seg); end
    n_checks++; if (D1_seg !== 8'hC0) begin n_fail++; $display("FAIL reset_d1_seg: got %h want C0", D1_seg); end
    @(posedge clk); #1;
    i_memwrite = 1'b0; i_addr = '0; i_wdata = '0;
    i_reset = 1'b0;
    foreach (addrs[i]) begin
      load(addrs[i], d, h);
      n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h want 0", i, d); end
      n_checks++; if (h !== 1'b1) begin n_fail++; $display("FAIL reset_hit[%0d]: got %b want 1", i, h); end
    end
  endtask

  task automatic test_led;
    logic [63:0] d;
    logic        h;
    store(A_LED, 64'hFFFF_FFFF_0000_A5A5);
    @(negedge clk);
    n_checks++; if (o_led !== 16'hA5A5) begin n_fail++; $display("FAIL led_out: got %h want A5A5", o_led); end
    @(posedge clk); #1;
    load(A_LED, d, h);
    n_checks++; if (d !== 64'h0000_0000_0000_A5A5) begin n_fail++; $display("FAIL led_read: got %h want A5A5", d); end
  endtask

  task automatic test_hex_scan;
    logic [31:0] vals [2];
    logic [63:0] d;
    logic        h;
    vals = '{32'h1234_5678, 32'hFEDC_BA90};
    foreach (vals[v]) begin
      int seen [4];
      seen = '{0, 0, 0, 0};
      store(A_HEX, {32'h0, vals[v]});
      for (int c = 0; c < 32; c++) begin
        int k;
        logic [3:0] n0, n1;
        @(negedge clk);
        k = -1;
        case (D0_a)
          4'b1110: k = 0;
          4'b1101: k = 1;
          4'b1011: k = 2;
          4'b0111: k = 3;
          default: k = -1;
        endcase
        n_checks++;
        if (k < 0) begin
          n_fail++; $display("FAIL scan_anode: got %b want one-hot-low", D0_a);
        end else begin
          seen[k]++;
          n0 = vals[v][4*k +: 4];
          n1 = vals[v][4*k+16 +: 4];
          n_checks++; if (D1_a !== D0_a) begin n_fail++; $display("FAIL scan_d1_a: got %b want %b", D1_a, D0_a); end
          n_checks++; if (D0_seg !== GLYPH[n0]) begin n_fail++; $display("FAIL scan_d0_seg k=%0d: got %h want %h", k, D0_seg, GLYPH[n0]); end
          n_checks++; if (D1_seg !== GLYPH[n1]) begin n_fail++; $display("FAIL scan_d1_seg k=%0d: got %h want %h", k, D1_seg, GLYPH[n1]); end
        end
      end
      @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
        n_checks++; if (seen[k] != 8) begin n_fail++; $display("FAIL scan_slots digit %0d: got %0d want 8", k, seen[k]); end
      end
      load(A_HEX, d, h);
      n_checks++; if (d !== {32'h0, vals[v]}) begin n_fail++; $display("FAIL hex_read: got %h want %h", d, vals[v]); end
    end
  endtask

  task automatic test_debounce;
    logic [63:0] d;
    logic        h;
    i_sw = 16'h0001;
    cycles(1);
    i_sw = 16'h0000;
    cycles(12);
    load(A_SWV, d, h);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL glitch_swval: got %h want 0", d); end
    i_sw = 16'h0001;
    cycles(12);
    load(A_SWV, d, h);
    n_checks++; if (d !== 64'h1) begin n_fail++; $display("FAIL hold_swval: got %h want 1", d); end
    load(A_SWE, d, h);
    n_checks++; if (d !== 64'h1) begin n_fail++; $display("FAIL edge_first_read: got %h want 1", d); end
    load(A_SWE, d, h);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL edge_second_read: got %h want 0", d); end
  endtask

  task automatic test_edge_clear_race;
    logic [63:0] d;
    logic        h;
    int          twos;
    twos = 0;
    i_sw = 16'h0000;
    cycles(12);
    i_sw = 16'h0001;
    cycles(12);
    // Read SW_EDGE every cycle while bit 1 rises: its edge must survive the clear.
    i_addr = A_SWE; i_memread = 1'b1; i_sw = 16'h0003;
    @(negedge clk);
    n_checks++; if (o_rdata !== 64'h1) begin n_fail++; $display("FAIL race_preclear: got %h want 1", o_rdata); end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_rdata === 64'h2) twos++;
      else begin
        n_checks++; if (o_rdata !== 64'h0) begin n_fail++; $display("FAIL race_stream c=%0d: got %h want 0 or 2", c, o_rdata); end
      end
    end
    @(posedge clk); #1;
    i_memread = 1'b0; i_addr = '0;
    n_checks++; if (twos != 1) begin n_fail++; $display("FAIL race_new_edge: got %0d reads of 0002 want 1", twos); end
    load(A_SWV, d, h);
    n_checks++; if (d !== 64'h3) begin n_fail++; $display("FAIL race_swval: got %h want 3", d); end
    load(A_SWE, d, h);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL race_edge_after: got %h want 0", d); end
  endtask

  task automatic test_unmapped;
    logic [63:0] d;
    logic        h;
    store(A_SWV, 64'h0);
    store(A_SWE, 64'hFFFF);
    store(BASE + 64'h20, 64'h0);
    load(A_SWV, d, h);
    n_checks++; if (d !== 64'h3) begin n_fail++; $display("FAIL ro_swval: got %h want 3", d); end
    load(A_SWE, d, h);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL ro_swedge: got %h want 0", d); end
    load(BASE + 64'h20, d, h);
    n_checks++; if (h !== 1'b0) begin n_fail++; $display("FAIL unmapped_hit: got %b want 0", h); end
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL unmapped_rdata: got %h want 0", d); end
    load(BASE + 64'h11, d, h);
    n_checks++; if (h !== 1'b0) begin n_fail++; $display("FAIL unaligned_hit: got %b want 0", h); end
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL unaligned_rdata: got %h want 0", d); end
    n_checks++; if (o_led !== 16'hA5A5) begin n_fail++; $display("FAIL unmapped_led: got %h want A5A5", o_led); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] d;
    logic        h;
    store(A_LED, 64'h0000_0000_1234_0F0F);
    store(A_HEX, 64'hDEAD_BEEF_CAFE_0001);
    load(A_LED, d, h);
    n_checks++; if (d !== 64'h0F0F) begin n_fail++; $display("FAIL b2b_led: got %h want 0F0F", d); end
    load(A_HEX, d, h);
    n_checks++; if (d !== 64'hCAFE_0001) begin n_fail++; $display("FAIL b2b_hex: got %h want CAFE0001", d); end
  endtask

  task automatic test_reset_midscan;
    logic [63:0] d;
    logic        h;
    cycles(5);
    i_reset = 1'b1;
    i_addr = A_HEX; i_wdata = 64'hFFFF_FFFF; i_memwrite = 1'b1;
    cycles(1);
    i_memwrite = 1'b0; i_addr = '0; i_wdata = '0;
    @(negedge clk);
    n_checks++; if (o_led !== 16'h0) begin n_fail++; $display("FAIL midreset_led: got %h want 0", o_led); end
    n_checks++; if (D0_a !== 4'b1110 || D1_a !== 4'b1110) begin n_fail++; $display("FAIL midreset_anodes: got %b/%b want 1110", D0_a, D1_a); end
    n_checks++; if (D0_seg !== 8'hC0 || D1_seg !== 8'hC0) begin n_fail++; $display("FAIL midreset_segs: got %h/%h want C0", D0_seg, D1_seg); end
    @(posedge clk); #1;
    i_reset = 1'b0;
    load(A_HEX, d, h);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL midreset_hex: got %h want 0", d); end
    load(A_SWV, d, h);
    n_checks++; if (d !== 64'h0) begin n_fail++; $display("FAIL midreset_swval: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_led();
    test_hex_scan();
    test_debounce();
    test_edge_clear_race();
    test_unmapped();
    test_back_to_back();
    test_reset_midscan();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
